// File: rtl/memory_arbiter_pkg.sv
// Shared core package for the instruction/data memory arbiter.
// Holds the arbiter FSM state enum, the port-owner encoding (I/D) and
// ctrltype, the command bundle the arbiter routes to the memory side.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_I = 2'd1,
    ST_WAIT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic        start;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
  } ctrltype;

  // Side that wins a simultaneous request under the DATA_PRIORITY setting.
  function automatic owner_e prio_side(input int unsigned data_priority);
    return (data_priority != 0) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: routes an instruction read port and a data read/write port
// onto a single memory command port, with at most one read outstanding.
// In IDLE the granted port is passed combinationally to mem_cmd_* (zero
// latency). Reads move the FSM to WAIT_I/WAIT_D until mem_rdata_valid;
// writes complete on acceptance.
//
// Ports:
//   clk, rst (async, active-high)
//   i_start/i_ready/i_addr/i_rdata/i_rdata_valid        instruction port
//   d_cmd_start/d_cmd_write/d_cmd_ready/d_addr/d_wdata/
//   d_wmask/d_rdata/d_rdata_valid                        data port
//   mem_cmd_start/mem_cmd_write/mem_cmd_ready/mem_addr/
//   mem_wdata/mem_wmask/mem_rdata/mem_rdata_valid        memory port
//
// Parameter DATA_PRIORITY: 1 = data wins ties, 0 = instruction wins ties.
// Macro MEMORY_ARBITER_ROUND_ROBIN_EN: ties go to the port not granted last;
// the pointer resets to the DATA_PRIORITY side.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned DATA_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_rdata_valid,
  input  logic        d_cmd_start,
  input  logic        d_cmd_write,
  output logic        d_cmd_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_rdata_valid,
  output logic        mem_cmd_start,
  output logic        mem_cmd_write,
  input  logic        mem_cmd_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid
);

  arb_state_e state, state_nxt;
  owner_e     grant, tie_winner;
  ctrltype    i_cmd, d_cmd, cmd_sel;
  logic       idle, acc_i, acc_d;

  // Reset gates the combinational command path so nothing leaks out while held.
  assign idle  = (state == ST_IDLE) && !rst;
  assign acc_i = i_ready && i_start;
  assign acc_d = d_cmd_ready && d_cmd_start;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  owner_e prio_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_ptr <= prio_side(DATA_PRIORITY);
    end else if (acc_i) begin
      prio_ptr <= OWN_D;
    end else if (acc_d) begin
      prio_ptr <= OWN_I;
    end
  end

  assign tie_winner = prio_ptr;
`else
  assign tie_winner = prio_side(DATA_PRIORITY);
`endif

  always_comb begin
    grant = tie_winner;
    if (i_start && !d_cmd_start) begin
      grant = OWN_I;
    end else if (d_cmd_start && !i_start) begin
      grant = OWN_D;
    end
  end

  always_comb begin
    i_cmd       = '0;
    i_cmd.start = i_start;
    i_cmd.addr  = i_addr;

    d_cmd       = '0;
    d_cmd.start = d_cmd_start;
    d_cmd.write = d_cmd_write;
    d_cmd.addr  = d_addr;
    d_cmd.wdata = d_wdata;
    d_cmd.wmask = d_wmask;

    cmd_sel = (grant == OWN_D) ? d_cmd : i_cmd;

    mem_cmd_start = idle && cmd_sel.start;
    mem_cmd_write = cmd_sel.write;
    mem_addr      = cmd_sel.addr;
    mem_wdata     = cmd_sel.wdata;
    mem_wmask     = cmd_sel.wmask;

    i_ready     = idle && (grant == OWN_I) && mem_cmd_ready;
    d_cmd_ready = idle && (grant == OWN_D) && mem_cmd_ready;
  end

  // Read data is broadcast; only the valid strobes are steered to the owner.
  assign i_rdata       = mem_rdata;
  assign d_rdata       = mem_rdata;
  assign i_rdata_valid = !rst && (state == ST_WAIT_I) && mem_rdata_valid;
  assign d_rdata_valid = !rst && (state == ST_WAIT_D) && mem_rdata_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (acc_i) begin
          state_nxt = ST_WAIT_I;
        end else if (acc_d && !d_cmd_write) begin
          state_nxt = ST_WAIT_D;
        end
      end
      ST_WAIT_I, ST_WAIT_D: begin
        if (mem_rdata_valid) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter (DATA_PRIORITY = 1).
// A transaction-level model tracks which port (if any) owns the outstanding
// read and which port wins a tie; a negedge process compares every output
// against it each cycle. Directed scenarios add literal expectations.
// Honours MEMORY_ARBITER_ROUND_ROBIN_EN to select the expected tie rule.
module tb_memory_arbiter;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_ready, i_rdata_valid;
  logic [31:0] i_addr, i_rdata;
  logic        d_cmd_start, d_cmd_write, d_cmd_ready, d_rdata_valid;
  logic [31:0] d_addr, d_wdata, d_wmask, d_rdata;
  logic        mem_cmd_start, mem_cmd_write, mem_cmd_ready, mem_rdata_valid;
  logic [31:0] mem_addr, mem_wdata, mem_wmask, mem_rdata;

  int total = 0;
  int bad   = 0;

  memory_arbiter #(.DATA_PRIORITY(1)) dut (
    .clk(clk), .rst(rst),
    .i_start(i_start), .i_ready(i_ready), .i_addr(i_addr),
    .i_rdata(i_rdata), .i_rdata_valid(i_rdata_valid),
    .d_cmd_start(d_cmd_start), .d_cmd_write(d_cmd_write),
    .d_cmd_ready(d_cmd_ready), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_rdata_valid(d_rdata_valid),
    .mem_cmd_start(mem_cmd_start), .mem_cmd_write(mem_cmd_write),
    .mem_cmd_ready(mem_cmd_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner 0 = nothing outstanding, 1 = instruction read, 2 = data read.
  // ptr_d = 1 means data wins the next tie.
  int m_owner = 0;
  bit m_ptr_d = 1'b1;

  function automatic bit data_wins();
    if (i_start && d_cmd_start) return RR ? m_ptr_d : 1'b1;
    return d_cmd_start;
  endfunction

  function automatic bit m_idle();
    return !rst && (m_owner == 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = 0;
      m_ptr_d = 1'b1;
    end else if (m_owner != 0) begin
      if (mem_rdata_valid) m_owner = 0;
    end else if (mem_cmd_ready && (i_start || d_cmd_start)) begin
      if (data_wins()) begin
        if (!d_cmd_write) m_owner = 2;
        m_ptr_d = 1'b0;
      end else begin
        m_owner = 1;
        m_ptr_d = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    bit wd, idl;
    wd  = data_wins();
    idl = m_idle();
    chk("mem_cmd_start", mem_cmd_start, idl && (i_start || d_cmd_start));
    chk("i_accept", i_ready && i_start, idl && i_start && !wd && mem_cmd_ready);
    chk("d_accept", d_cmd_ready && d_cmd_start, idl && d_cmd_start && wd && mem_cmd_ready);
    if (!idl) begin
      chk("i_ready_busy", i_ready, 0);
      chk("d_ready_busy", d_cmd_ready, 0);
    end
    if (idl && (i_start || d_cmd_start)) begin
      chk("mem_addr", mem_addr, wd ? d_addr : i_addr);
      chk("mem_cmd_write", mem_cmd_write, wd && d_cmd_write);
      if (wd && d_cmd_write) begin
        chk("mem_wdata", mem_wdata, d_wdata);
        chk("mem_wmask", mem_wmask, d_wmask);
      end
    end
    chk("i_rdata_valid", i_rdata_valid, !rst && m_owner == 1 && mem_rdata_valid);
    chk("d_rdata_valid", d_rdata_valid, !rst && m_owner == 2 && mem_rdata_valid);
    chk("i_rdata", i_rdata, mem_rdata);
    chk("d_rdata", d_rdata, mem_rdata);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_d [4];
    rst = 1'b1;
    i_start = 1'b1; i_addr = 32'h0;
    d_cmd_start = 1'b0; d_cmd_write = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    mem_cmd_ready = 1'b1; mem_rdata = 32'h0; mem_rdata_valid = 1'b0;
    cyc(); cyc();
    mid();
    chk("rst_mem_cmd_start", mem_cmd_start, 0);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_d_ready", d_cmd_ready, 0);
    cyc();
    rst = 1'b0;

    // Instruction read only.
    i_addr = 32'h100;
    mid();
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_i_ready", i_ready, 1);
    cyc();
    i_start = 1'b0;
    cyc();
    mem_rdata = 32'h13; mem_rdata_valid = 1'b1;
    mid();
    chk("t1_i_valid", i_rdata_valid, 1);
    chk("t1_i_rdata", i_rdata, 32'h13);
    chk("t1_d_valid", d_rdata_valid, 0);
    cyc();
    mem_rdata_valid = 1'b0;

    // Simultaneous: data wins, instruction follows after the response.
    i_start = 1'b1; i_addr = 32'h200;
    d_cmd_start = 1'b1; d_cmd_write = 1'b0; d_addr = 32'h8000;
    mid();
    chk("t2_d_ready", d_cmd_ready, 1);
    chk("t2_i_ready", i_ready, 0);
    chk("t2_mem_addr", mem_addr, 32'h8000);
    cyc();
    d_cmd_start = 1'b0;
    mid();
    chk("t2_i_wait", i_ready, 0);
    cyc();
    mem_rdata = 32'h55; mem_rdata_valid = 1'b1;
    mid();
    chk("t2_d_valid", d_rdata_valid, 1);
    chk("t2_i_resp_cycle", i_ready, 0);
    cyc();
    mem_rdata_valid = 1'b0;
    mid();
    chk("t2_i_ready_after", i_ready, 1);
    chk("t2_mem_addr_i", mem_addr, 32'h200);
    cyc();
    i_start = 1'b0;
    mem_rdata = 32'h66; mem_rdata_valid = 1'b1;
    cyc();
    mem_rdata_valid = 1'b0;

    // Data write completes on acceptance.
    d_cmd_start = 1'b1; d_cmd_write = 1'b1; d_addr = 32'h10;
    d_wdata = 32'hDEADBEEF; d_wmask = 32'hFFFFFFFF;
    mid();
    chk("t3_d_ready", d_cmd_ready, 1);
    chk("t3_mem_write", mem_cmd_write, 1);
    chk("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
    cyc();
    d_cmd_start = 1'b0; d_cmd_write = 1'b0;

    // Stalled memory; a stray rdata_valid while idle is ignored.
    i_start = 1'b1; i_addr = 32'h300; mem_cmd_ready = 1'b0; mem_rdata_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("t4_i_ready_stall", i_ready, 0);
      chk("t4_idle_i_valid", i_rdata_valid, 0);
      chk("t4_idle_d_valid", d_rdata_valid, 0);
      cyc();
      mem_rdata_valid = 1'b0;
    end
    mem_cmd_ready = 1'b1;
    mid();
    chk("t4_i_ready_go", i_ready, 1);
    cyc();
    i_start = 1'b0;
    mem_rdata_valid = 1'b1;
    cyc();
    mem_rdata_valid = 1'b0;

    // Reset mid data read drops the transaction.
    d_cmd_start = 1'b1; d_addr = 32'h40;
    cyc();
    d_cmd_start = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    mem_rdata = 32'h77; mem_rdata_valid = 1'b1;
    mid();
    chk("t5_d_valid", d_rdata_valid, 0);
    chk("t5_i_valid", i_rdata_valid, 0);
    cyc();
    mem_rdata_valid = 1'b0;

    // Both ports requesting reads continuously.
    exp_d[0] = 1'b1; exp_d[1] = !RR; exp_d[2] = 1'b1; exp_d[3] = !RR;
    i_start = 1'b1; i_addr = 32'h400;
    d_cmd_start = 1'b1; d_addr = 32'h500;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("t6_grant_d", d_cmd_ready, exp_d[k]);
      chk("t6_grant_i", i_ready, !exp_d[k]);
      cyc();
      mem_rdata_valid = 1'b1;
      cyc();
      mem_rdata_valid = 1'b0;
    end
    i_start = 1'b0; d_cmd_start = 1'b0;
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter DATA_PRIORITY, default 1, 1 = data port wins simultaneous requests, 0 = instruction port wins.
REQ-002 Clock and reset SHALL be exactly: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  single clock, all state on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 i_start  in  1  instruction read request.
REQ-006 i_ready  out  1  instruction request accepted this cycle when i_start also high.
REQ-007 i_addr  in  32  instruction byte address.
REQ-008 i_rdata  out  32  instruction read data.
REQ-009 i_rdata_valid  out  1  one-cycle pulse, i_rdata valid.
REQ-010 d_cmd_start  in  1  data request.
REQ-011 d_cmd_write  in  1  1 = write, 0 = read.
REQ-012 d_cmd_ready  out  1  data request accepted this cycle when d_cmd_start also high.
REQ-013 d_addr  in  32  data byte address.
REQ-014 d_wdata  in  32  write data.
REQ-015 d_wmask  in  32  bit-level write mask.
REQ-016 d_rdata  out  32  data read result.
REQ-017 d_rdata_valid  out  1  one-cycle pulse, d_rdata valid.
REQ-018 mem_cmd_start  out  1  downstream request.
REQ-019 mem_cmd_write  out  1  downstream write flag.
REQ-020 mem_cmd_ready  in  1  downstream can accept.
REQ-021 mem_addr / mem_wdata / mem_wmask  out  32 each  downstream command fields.
REQ-022 mem_rdata  in  32  downstream read data.
REQ-023 mem_rdata_valid  in  1  downstream read-data pulse.

Function
REQ-024 FSM states: IDLE, WAIT_I, WAIT_D. At most one read SHALL be outstanding.
REQ-025 In IDLE the granted requester SHALL be routed combinationally to mem_cmd_*, giving zero-cycle command latency. mem_cmd_start SHALL equal the granted start.
REQ-026 Grant when both are pending SHALL follow DATA_PRIORITY. When only one is pending, that one SHALL be granted.
REQ-027 i_ready SHALL be (state==IDLE && grant==I && mem_cmd_ready). d_cmd_ready SHALL follow the same rule with grant==D. Both SHALL be 0 outside IDLE.
REQ-028 Accepted instruction read: transition IDLE->WAIT_I. Accepted data read: transition IDLE->WAIT_D.
REQ-029 Accepted data write SHALL complete on acceptance. The FSM SHALL stay IDLE and SHALL produce no d_rdata_valid.
REQ-030 In WAIT_x, mem_rdata_valid SHALL produce a pulse on x_rdata_valid in the same cycle, with x_rdata = mem_rdata. The FSM SHALL then go to IDLE on the next edge; a new acceptance is possible no earlier than the cycle after the response.
REQ-031 mem_rdata_valid in IDLE SHALL be ignored; both *_rdata_valid outputs stay 0.
REQ-032 The non-owner *_rdata_valid SHALL never be asserted. *_rdata SHALL equal mem_rdata at all times; only the valid signals are gated.
REQ-033 A losing requester SHALL hold its request until it is accepted. The arbiter SHALL store no request.

Reset
REQ-034 rst SHALL force state=IDLE, clear the owner, and (with REQ-036) set the priority pointer to the DATA_PRIORITY side. It SHALL then hold mem_cmd_start=0, i_ready=0, d_cmd_ready=0, i_rdata_valid=0, d_rdata_valid=0.
REQ-035 Reset asserted mid-read SHALL drop the outstanding transaction. A late mem_rdata_valid SHALL then be ignored per REQ-031.

Configuration
REQ-036 Macro MEMORY_ARBITER_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, grant the port not granted last. The priority pointer is initialised from DATA_PRIORITY at reset.
- Undefined: fixed priority per DATA_PRIORITY, and no pointer register exists.

Structure
REQ-037 The FSM state enum and the owner encoding (I/D) SHALL live in the shared core package, next to ctrltype. No sub-module SHALL be used; the block is a single module instanced between Core and the memory.

Verification
REQ-038 Instruction read only: i_start=1, i_addr=0x100, mem_cmd_ready=1, mem_rdata=0x00000013 two cycles later -> mem_addr=0x100 in the same cycle, i_rdata_valid pulse, i_rdata=0x13, d_rdata_valid=0.
REQ-039 Simultaneous start, DATA_PRIORITY=1: i_addr=0x200, data read at 0x8000 -> data granted first and i_ready=0. The instruction is accepted in the cycle after d_rdata_valid.
REQ-040 Data write 0xDEADBEEF at 0x10 with wmask=0xFFFFFFFF -> d_cmd_ready=1 and mem_cmd_write=1 in the same cycle, FSM stays IDLE, no rdata_valid.
REQ-041 mem_cmd_ready=0 for 5 cycles with i_start high -> i_ready=0 and the FSM stays IDLE. Acceptance occurs in the first cycle that ready=1.
REQ-042 rst pulsed while in WAIT_D, then mem_rdata_valid=1 -> d_rdata_valid and i_rdata_valid remain 0.
REQ-043 With MEMORY_ARBITER_ROUND_ROBIN_EN, both ports requesting continuously -> grants alternate D, I, D, I.
